flit_fifo_buffer: RTL



---
 rtl/noc_buffer_pkg.sv | 11 +
 rtl/buffer_ptr.sv | 42 ++++
 rtl/flit_fifo_buffer.sv | 127 ++++++++++++
 3 files changed

// File: rtl/noc_buffer_pkg.sv
// Shared flit type and error-flag bit positions for the router input buffers.
package noc_buffer_pkg;

    localparam int FLIT_WIDTH = 17;

    typedef logic [FLIT_WIDTH-1:0] flit_t;

    localparam int ERR_OVF = 1;
    localparam int ERR_UDF = 0;

endpackage

// File: rtl/buffer_ptr.sv
// Wrapping index into a DEPTH-entry buffer; steps by one on inc_i, wraps DEPTH-1 -> 0.
module buffer_ptr
    import noc_buffer_pkg::*;
#(
    parameter int DEPTH = 5,
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             inc_i,
    output logic [PTR_W-1:0] ptr_o
);

    logic [PTR_W-1:0] ptr_q;
    logic [PTR_W-1:0] ptr_d;

    // Next index: explicit compare keeps non-power-of-two depths in range.
    always_comb begin
        ptr_d = ptr_q;
        if (inc_i) begin
            if (ptr_q == PTR_W'(DEPTH - 1)) begin
                ptr_d = {PTR_W{1'b0}};
            end else begin
                ptr_d = ptr_q + PTR_W'(1);
            end
        end else begin
            ptr_d = ptr_q;
        end
    end

    // Index register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ptr_q <= {PTR_W{1'b0}};
        end else begin
            ptr_q <= ptr_d;
        end
    end

    assign ptr_o = ptr_q;

endmodule

// File: rtl/flit_fifo_buffer.sv
// Circular flit FIFO for one router input port with occupancy, credit return and sticky errors.
// Optional same-cycle empty bypass enabled by defining FLIT_FIFO_BYPASS_EN.
module flit_fifo_buffer
    import noc_buffer_pkg::*;
#(
    parameter int DATA_WIDTH = FLIT_WIDTH,
    parameter int DEPTH      = 5,
    parameter int CNT_W      = $clog2(DEPTH + 1)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  receive_i,
    input  logic                  send_i,
    input  logic [DATA_WIDTH-1:0] data_i,
    output logic [DATA_WIDTH-1:0] data_o,
    output logic                  valid_o,
    output logic                  full_o,
    output logic                  empty_o,
    output logic [CNT_W-1:0]      count_o,
    output logic                  credit_o,
    output logic [1:0]            err_o
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [DATA_WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0]      rd_ptr_s;
    logic [PTR_W-1:0]      wr_ptr_s;
    logic [CNT_W-1:0]      count_q;
    logic [CNT_W-1:0]      count_d;
    logic                  credit_q;
    logic                  credit_d;
    logic [1:0]            err_q;
    logic [1:0]            err_d;
    logic                  empty_s;
    logic                  full_s;
    logic                  bypass_s;
    logic                  push_s;
    logic                  pop_s;
    logic                  ovf_s;
    logic                  udf_s;

    // Accept/reject decisions for this cycle, derived from occupancy.
    always_comb begin
        empty_s  = (count_q == {CNT_W{1'b0}});
        full_s   = (count_q == CNT_W'(DEPTH));
`ifdef FLIT_FIFO_BYPASS_EN
        bypass_s = empty_s && receive_i && send_i;
`else
        bypass_s = 1'b0;
`endif
        push_s   = receive_i && (!full_s || send_i) && !bypass_s;
        pop_s    = send_i && !empty_s;
        ovf_s    = receive_i && full_s && !send_i;
        udf_s    = send_i && empty_s && !bypass_s;
    end

    // Occupancy, credit and sticky-error next state.
    always_comb begin
        count_d = count_q;
        case ({push_s, pop_s})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
        credit_d        = pop_s || bypass_s;
        err_d           = err_q;
        err_d[ERR_OVF]  = err_q[ERR_OVF] | ovf_s;
        err_d[ERR_UDF]  = err_q[ERR_UDF] | udf_s;
    end

    // Status registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_q  <= {CNT_W{1'b0}};
            credit_q <= 1'b0;
            err_q    <= 2'b00;
        end else begin
            count_q  <= count_d;
            credit_q <= credit_d;
            err_q    <= err_d;
        end
    end

    // Flit storage; contents are intentionally left unreset.
    always_ff @(posedge clk) begin
        if (push_s) begin
            mem_q[wr_ptr_s] <= data_i;
        end
    end

    buffer_ptr #(.DEPTH(DEPTH)) u_wr_ptr (
        .clk   (clk),
        .rst   (rst),
        .inc_i (push_s),
        .ptr_o (wr_ptr_s)
    );

    buffer_ptr #(.DEPTH(DEPTH)) u_rd_ptr (
        .clk   (clk),
        .rst   (rst),
        .inc_i (pop_s),
        .ptr_o (rd_ptr_s)
    );

    // Head presentation; with bypass an empty FIFO forwards the incoming flit.
    always_comb begin
        data_o  = mem_q[rd_ptr_s];
        valid_o = !empty_s;
`ifdef FLIT_FIFO_BYPASS_EN
        if (empty_s && receive_i) begin
            data_o  = data_i;
            valid_o = 1'b1;
        end else begin
            data_o  = mem_q[rd_ptr_s];
            valid_o = !empty_s;
        end
`endif
    end

    assign full_o   = full_s;
    assign empty_o  = empty_s;
    assign count_o  = count_q;
    assign credit_o = credit_q;
    assign err_o    = err_q;

endmodule
